// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  localparam int unsigned DefaultClockDiv = 139;
  localparam int unsigned DefaultDataBits = 8;
  localparam logic        RxIdleLevel     = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input pin; reset value is configurable.
module uart_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with a one-deep holding register and valid/ready handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity mismatches.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_DIV = DefaultClockDiv,
  parameter int unsigned DATA_BITS = DefaultDataBits
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(CLOCK_DIV);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLOCK_DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CLOCK_DIV - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 rx_s, rx_d1_q;
  logic                 sample, fall, deliver;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 pe_q, pe_d;
`endif

  uart_sync #(
    .ResetVal(RxIdleLevel)
  ) u_rx_sync (
    .clk_i (clock),
    .rst_ni(reset_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign sample = (cnt_q == '0);
  assign fall   = rx_d1_q & ~rx_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = sample ? FullLoad : cnt_q - 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif

    if (valid_q && data_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = cnt_q;
        if (fall) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (sample) begin
          if (!rx_s) begin
            state_d = StData;
            idx_d   = '0;
`ifdef UART_RX_PARITY_EN
            par_d   = 1'b0;
            perr_d  = 1'b0;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (sample) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          par_d   = par_q ^ rx_s;
          if (idx_q == LastIdx) state_d = StParity;
`else
          if (idx_q == LastIdx) state_d = StStop;
`endif
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (sample) begin
          perr_d  = par_q ^ rx_s;
          state_d = StStop;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        if (sample) begin
`ifdef UART_RX_PARITY_EN
          pe_d = perr_q;
`endif
          // Leave mid-stop so a back-to-back start edge is not missed.
          if (rx_s) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d    = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (deliver) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      rx_d1_q <= RxIdleLevel;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      rx_d1_q <= rx_s;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign busy          = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a byte scoreboard fed by the stimulus and drained on delivery.
module tb_uart_rx;

  localparam int unsigned ClkDiv   = 16;
  localparam int unsigned DataBits = 8;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                rx = 1'b1;
  logic                data_ready = 1'b0;
  logic [DataBits-1:0] data_out;
  logic                data_valid;
  logic                framing_error;
  logic                overrun;
  logic                parity_error;
  logic                busy;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int deliv_cnt = 0;
  logic [7:0] exp_q[$];
  logic valid_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx #(
    .CLOCK_DIV(ClkDiv),
    .DATA_BITS(DataBits)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun      (overrun),
    .parity_error (parity_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit time; called on a falling clock edge.
  task automatic bit_period(input logic b);
    rx = b;
    repeat (ClkDiv) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_period((^d) ^ par_flip);
`endif
    bit_period(stop);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !data_valid; i++) @(negedge clock);
    check(tag, 32'(data_valid), 32'd1);
  endtask

  task automatic accept();
    data_ready = 1'b1;
    @(negedge clock);
    data_ready = 1'b0;
  endtask

  // Monitor: pulse counters and scoreboard drain on each new delivery.
  always @(negedge clock) begin
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (parity_error) pe_cnt++;
    if (data_valid && !valid_prev) begin
      deliv_cnt++;
      if (exp_q.size() == 0) check("sb_unexpected_byte", 32'(data_out), 32'hxxxx_xxxx);
      else check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
    valid_prev = data_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    rx = 1'b1;
    data_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_pe", 32'(parity_error), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Single byte, consumer not ready.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_valid("t1_valid", 40);
    check("t1_data", 32'(data_out), 32'hA5);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_fe", 32'(fe_cnt), 32'd0);
    check("t1_ov", 32'(ov_cnt), 32'd0);
    check("t1_pe", 32'(pe_cnt), 32'd0);
    accept();
    check("t1_valid_drop", 32'(data_valid), 32'd0);
    check("t1_data_hold", 32'(data_out), 32'hA5);

    // Back-to-back, holding register full on the second frame.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clock);
    check("t2_ov", 32'(ov_cnt), 32'd1);
    check("t2_data_kept", 32'(data_out), 32'h3C);
    check("t2_valid", 32'(data_valid), 32'd1);
    check("t2_fe", 32'(fe_cnt), 32'd0);
    accept();
    check("t2_valid_drop", 32'(data_valid), 32'd0);
    check("t2_deliveries", 32'(deliv_cnt), 32'd2);

    // Stop bit low, line held low 40 cycles.
    send_frame(8'h55, 1'b0);
    repeat (24) @(negedge clock);
    check("t3_fe", 32'(fe_cnt), 32'd1);
    check("t3_busy_break", 32'(busy), 32'd1);
    check("t3_valid", 32'(data_valid), 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clock);
    check("t3_busy_idle", 32'(busy), 32'd0);
    check("t3_deliveries", 32'(deliv_cnt), 32'd2);

    // Short low glitch: false start.
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
    check("t4_busy_start", 32'(busy), 32'd1);
    repeat (30) @(negedge clock);
    check("t4_busy_idle", 32'(busy), 32'd0);
    check("t4_valid", 32'(data_valid), 32'd0);
    check("t4_fe", 32'(fe_cnt), 32'd1);
    check("t4_ov", 32'(ov_cnt), 32'd1);
    check("t4_deliveries", 32'(deliv_cnt), 32'd2);

    // Reset in the middle of bit 3 of 0xFF.
    bit_period(1'b0);
    for (int i = 0; i < 3; i++) bit_period(1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clock);
    check("t5_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_valid", 32'(data_valid), 32'd0);
    check("t5_rst_data", 32'(data_out), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_valid("t5_valid", 40);
    check("t5_data", 32'(data_out), 32'h12);
    accept();

`ifdef UART_RX_PARITY_EN
    // Wrong parity: byte still delivered, parity pulse at the stop sample.
    par_flip = 1'b1;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    par_flip = 1'b0;
    wait_valid("t6_valid", 40);
    check("t6_data", 32'(data_out), 32'h01);
    check("t6_pe", 32'(pe_cnt), 32'd1);
    check("t6_fe", 32'(fe_cnt), 32'd1);
    accept();
`else
    check("t6_pe_none", 32'(pe_cnt), 32'd0);
`endif

    repeat (4) @(negedge clock);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
